fft_peak_detector: RTL and testbench
====================================

Name: fft_peak_detector

Overview:
- AXI-Stream slave that consumes the complex output frame of the 2048-point FFT core (its m_axis_data side) and reports the strongest spectral bin per frame.
- Computes |X|^2 per bin, tracks the maximum over the positive-frequency half, and presents bin index and magnitude on a valid/ready result port.
- Sits between the FFT core and downstream pitch/display logic. It is the consumer counterpart to the sample-feeding master on the FFT input.

Parameters:
- NFFT, 2048, frame length in samples/bins (power of two)
- LOG2N, 11, log2(NFFT); width of bin index
- DW, 16, width of each signed real/imag component

Ports:
- clk_in  input  1  system clock, 100 MHz
- rst_in  input  1  asynchronous, active-high reset
- s_axis_tdata  input  2*DW  [DW-1:0] = real, [2*DW-1:DW] = imag, both two's complement
- s_axis_tvalid  input  1  FFT output beat valid
- s_axis_tlast  input  1  last beat of frame
- s_axis_tready  output  1  block accepts beat
- peak_bin  output  LOG2N  index of maximum bin
- peak_mag  output  2*DW+1  re^2+im^2 of that bin, unsigned
- peak_valid  output  1  result available
- peak_ready  input  1  downstream accepts result
- frame_err  output  1  tlast mismatch in reported frame; valid with peak_valid

Behaviour:
- Reset (async, active-high): s_axis_tready=0 while rst_in=1, then 1 on the first clock after release. peak_bin=0, peak_mag=0, peak_valid=0, frame_err=0. Bin counter, pipeline valids and running max are cleared. FSM goes to ACCUM.
- A beat is accepted on any rising edge with s_axis_tvalid && s_axis_tready. Gaps in tvalid are allowed. The bin counter increments only on acceptance.
- Pipeline has 3 registered stages:
  - S1: re*re and im*im, 2*DW bits each, signed multiply.
  - S2: sum into 2*DW+1 bits, tagged with bin index and a last flag.
  - S3: compare and update the running max.
- Candidate window: bins 1..NFFT/2-1. Bin 0 (DC) and bins NFFT/2..NFFT-1 flow through the pipeline but never update the max.
- Update rule: replace the max only if the candidate is strictly greater. Ties keep the lowest index. The running max starts at mag 0, bin 0 each frame. An all-zero frame therefore reports bin 0, mag 0.
- End of frame is the first accepted beat with s_axis_tlast=1 or bin counter == NFFT-1, whichever comes first.
- frame_err is set if tlast arrives at counter != NFFT-1, or if counter == NFFT-1 arrives without tlast.
- On end of frame:
  - The bin counter resets to 0.
  - The FSM moves ACCUM -> DRAIN and s_axis_tready drops on the next cycle.
- DRAIN: wait for the tagged last beat to leave S3, then -> REPORT.
- REPORT: peak_valid=1, with peak_bin, peak_mag and frame_err held stable.
  - Latency: peak_valid rises 3 cycles after the edge that accepted the final beat.
  - On peak_valid && peak_ready: peak_valid=0, running max and frame_err cleared, FSM -> ACCUM, s_axis_tready=1 on the following cycle.
  - peak_ready held high gives a 1-cycle REPORT.
- s_axis_tready is 1 only in ACCUM. No beat of the next frame enters before its result is accepted.
- Extremes: re=im=-2^(DW-1) gives peak_mag=2^(2*DW-1) with no overflow; the +1 bit carries the sum.
- Reset mid-frame or mid-REPORT discards everything; the next frame starts at bin 0.

Optional Feature:
- Macro FFT_PEAK_DC_EN.
- When defined: bin 0 is a candidate, giving the window 0..NFFT/2-1. The running max starts at -1 (invalid) so bin 0 always loads first.
- When undefined: behaviour is exactly as above, with DC excluded.

Test Plan:
- Tone frame: bin 100 = (re 1000, im 0), all other bins 0, tlast on beat 2047 -> peak_bin=100, peak_mag=1000000, frame_err=0, peak_valid 3 cycles after last accept.
- Tie/DC: bin 0 = (20000,0), bins 50 and 300 = (0,-500), tlast correct.
  - Macro off -> peak_bin=50, peak_mag=250000.
  - Macro on -> peak_bin=0, peak_mag=400000000.
- Mirror and extreme: bin 1500 = (-32768,-32768) and bin 7 = (-32768,-32768) -> peak_bin=7, peak_mag=2147483648.
- Framing errors:
  - Early tlast on beat 999 (counter 999) -> frame_err=1, result reported, next frame starts at bin 0.
  - 2048 beats with no tlast -> frame_err=1 after beat 2047.
- Backpressure: random tvalid gaps plus peak_ready held low 20 cycles -> s_axis_tready=0 throughout DRAIN/REPORT, outputs stable, no beats lost. Two back-to-back frames report bins 10 then 20.
- Reset mid-frame: assert rst_in at beat 800 -> outputs clear immediately. A fresh full frame with peak at bin 5 then reports bin 5, frame_err=0.

Source files
------------

// File: rtl/fft_peak_detector.sv
// fft_peak_detector: AXI-Stream sink for a complex FFT output frame. Computes re^2+im^2 per bin
// in a three-stage pipeline, tracks the strongest bin of the positive-frequency half and hands the
// result out on a valid/ready port together with a framing-error flag.
// Optional feature: define FFT_PEAK_DC_EN to make bin 0 (DC) a peak candidate.
module fft_peak_detector #(
  parameter int unsigned NFFT  = 2048,
  parameter int unsigned LOG2N = 11,
  parameter int unsigned DW    = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [2*DW-1:0]      s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [LOG2N-1:0]     peak_bin,
  output logic [2*DW:0]        peak_mag,
  output logic                 peak_valid,
  input  logic                 peak_ready,
  output logic                 frame_err
);

  localparam int unsigned PW = 2 * DW;      // product width
  localparam int unsigned MW = 2 * DW + 1;  // magnitude width, extra bit carries the sum
  localparam logic [LOG2N-1:0] LastBin = LOG2N'(NFFT - 1);

  typedef enum logic [1:0] {StAccum, StDrain, StReport} state_e;

  state_e             state_q;
  logic               tready_q;
  logic               peak_valid_q;
  logic [LOG2N-1:0]   peak_bin_q;
  logic [MW-1:0]      peak_mag_q;
  logic               frame_err_q;
  logic               err_q;

  logic [LOG2N-1:0]   cnt_q, cnt_d;

  logic               s1_vld_q, s1_last_q;
  logic [LOG2N-1:0]   s1_bin_q;
  logic [PW-1:0]      s1_re2_q, s1_im2_q;

  logic               s2_vld_q, s2_last_q;
  logic [LOG2N-1:0]   s2_bin_q;
  logic [MW-1:0]      s2_mag_q;

  logic               s3_vld_q, s3_last_q;
  logic [LOG2N-1:0]   max_bin_q;
  logic [MW-1:0]      max_mag_q;
`ifdef FFT_PEAK_DC_EN
  logic               max_vld_q;  // low means "no candidate yet", i.e. max is -1
`endif

  logic               accept;
  logic               at_last;
  logic               eof;
  logic               eof_err;
  logic               clr;
  logic               in_window;
  logic               upd;
  logic signed [PW-1:0] re_w, im_w;

  assign s_axis_tready = tready_q;
  assign peak_valid    = peak_valid_q;
  assign peak_bin      = peak_bin_q;
  assign peak_mag      = peak_mag_q;
  assign frame_err     = frame_err_q;

  // Beat acceptance and end-of-frame detection
  always_comb begin
    accept  = s_axis_tvalid & tready_q;
    at_last = (cnt_q == LastBin);
    eof     = accept & (s_axis_tlast | at_last);
    // tlast and the terminal count must coincide; either one alone is a framing error
    eof_err = s_axis_tlast ^ at_last;
    clr     = peak_valid_q & peak_ready;
    re_w    = {{DW{s_axis_tdata[DW-1]}}, s_axis_tdata[DW-1:0]};
    im_w    = {{DW{s_axis_tdata[PW-1]}}, s_axis_tdata[PW-1:DW]};
  end

  // Bin counter next state: advances per accepted beat, wraps at end of frame
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = eof ? '0 : cnt_q + LOG2N'(1);
    end
  end

  // Bin counter register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // S1: square both components and tag the beat with its bin and end-of-frame flag
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_bin_q  <= '0;
      s1_re2_q  <= '0;
      s1_im2_q  <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_last_q <= s_axis_tlast | at_last;
        s1_bin_q  <= cnt_q;
        // Squares are never negative, so the low PW bits hold them exactly (max 2^(PW-2))
        s1_re2_q  <= PW'(re_w * re_w);
        s1_im2_q  <= PW'(im_w * im_w);
      end
    end
  end

  // S2: sum of squares into MW bits
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_bin_q  <= '0;
      s2_mag_q  <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_last_q <= s1_last_q;
        s2_bin_q  <= s1_bin_q;
        s2_mag_q  <= {1'b0, s1_re2_q} + {1'b0, s1_im2_q};
      end
    end
  end

  // S3 candidate test: positive-frequency half only, strictly-greater so ties keep the lower bin
  always_comb begin
`ifdef FFT_PEAK_DC_EN
    in_window = s2_vld_q & ~s2_bin_q[LOG2N-1];
    upd       = in_window & (~max_vld_q | (s2_mag_q > max_mag_q));
`else
    in_window = s2_vld_q & ~s2_bin_q[LOG2N-1] & (s2_bin_q != '0);
    upd       = in_window & (s2_mag_q > max_mag_q);
`endif
  end

  // S3: running maximum, cleared when the result is taken
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s3_vld_q  <= 1'b0;
      s3_last_q <= 1'b0;
      max_bin_q <= '0;
      max_mag_q <= '0;
`ifdef FFT_PEAK_DC_EN
      max_vld_q <= 1'b0;
`endif
    end else begin
      s3_vld_q  <= s2_vld_q;
      s3_last_q <= s2_vld_q & s2_last_q;
      if (clr) begin
        max_bin_q <= '0;
        max_mag_q <= '0;
`ifdef FFT_PEAK_DC_EN
        max_vld_q <= 1'b0;
`endif
      end else if (upd) begin
        max_bin_q <= s2_bin_q;
        max_mag_q <= s2_mag_q;
`ifdef FFT_PEAK_DC_EN
        max_vld_q <= 1'b1;
`endif
      end
    end
  end

  // Frame FSM with registered ready, result and error outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StAccum;
      tready_q     <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      frame_err_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          tready_q <= 1'b1;
          if (eof) begin
            state_q  <= StDrain;
            tready_q <= 1'b0;
            err_q    <= eof_err;
          end
        end
        StDrain: begin
          // The tagged final beat has been folded into the max once it leaves S3
          if (s3_vld_q && s3_last_q) begin
            state_q      <= StReport;
            peak_valid_q <= 1'b1;
            peak_bin_q   <= max_bin_q;
            peak_mag_q   <= max_mag_q;
            frame_err_q  <= err_q;
          end
        end
        StReport: begin
          if (peak_ready) begin
            state_q      <= StAccum;
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            tready_q     <= 1'b1;
          end
        end
        default: begin
          state_q  <= StAccum;
          tready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_detector.sv
// Self-checking bench for fft_peak_detector: table of frames driven through the stream port,
// expected peak results queued on drive and compared when the result handshake happens.
module tb_fft_peak_detector;

  localparam int NFFT = 2048;

  logic        clk_in;
  logic        rst_in;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [10:0] peak_bin;
  logic [32:0] peak_mag;
  logic        peak_valid;
  logic        peak_ready;
  logic        frame_err;

  fft_peak_detector #(
    .NFFT (2048),
    .LOG2N(11),
    .DW   (16)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .peak_valid   (peak_valid),
    .peak_ready   (peak_ready),
    .frame_err    (frame_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int          b0, b1, b2;   // nonzero bins, -1 unused
    logic [31:0] d0, d1, d2;
    int          nbeats;
    bit          tl;           // tlast on the final beat
    int          ebin;
    longint      emag;
    bit          eerr;
  } vec_t;

  typedef struct {
    int     bin;
    longint mag;
    bit     err;
  } exp_t;

  vec_t  vecs[11];
  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  bit    pv_prev = 0;
  logic [44:0] hold;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [31:0] cx(input int re, input int im);
    logic [15:0] r, i;
    r = re[15:0];
    i = im[15:0];
    return {i, r};
  endfunction

  function automatic logic [31:0] beat_data(input int idx, input int b);
    if (vecs[idx].b0 == b) return vecs[idx].d0;
    if (vecs[idx].b1 == b) return vecs[idx].d1;
    if (vecs[idx].b2 == b) return vecs[idx].d2;
    return 32'd0;
  endfunction

  function automatic vec_t mk(input int b0, input logic [31:0] d0, input int b1,
                              input logic [31:0] d1, input int b2, input logic [31:0] d2,
                              input int nbeats, input bit tl, input int ebin,
                              input longint emag, input bit eerr);
    vec_t v;
    v.b0 = b0; v.d0 = d0; v.b1 = b1; v.d1 = d1; v.b2 = b2; v.d2 = d2;
    v.nbeats = nbeats; v.tl = tl; v.ebin = ebin; v.emag = emag; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one beat and hold it until accepted
  task automatic put_beat(input logic [31:0] d, input logic l);
    bit ok;
    ok = 0;
    @(negedge clk_in);
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int w = 0; w < 1000; w++) begin
      if (s_axis_tready) begin
        @(posedge clk_in);
        #1;
        acc_cyc = cyc;
        ok = 1;
        break;
      end
      @(negedge clk_in);
    end
    if (!ok) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic send_frame(input int idx, input bit gaps);
    exp_t e;
    e.bin = vecs[idx].ebin;
    e.mag = vecs[idx].emag;
    e.err = vecs[idx].eerr;
    sb.push_back(e);
    for (int b = 0; b < vecs[idx].nbeats; b++) begin
      put_beat(beat_data(idx, b), (b == vecs[idx].nbeats - 1) && vecs[idx].tl);
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
  endtask

  task automatic wait_empty();
    bit done;
    done = 0;
    for (int w = 0; w < 5000; w++) begin
      if (sb.size() == 0) begin
        done = 1;
        break;
      end
      @(negedge clk_in);
    end
    if (!done) chk("result_timeout", longint'(sb.size()), 0);
  endtask

  // Result monitor: latency, stability, ready blocking and scoreboard compare
  always begin
    exp_t e;
    @(negedge clk_in);
    #1;
    if (!rst_in && peak_valid) begin
      if (!pv_prev) chk("latency", longint'(cyc - acc_cyc), 3);
      else chk("hold_stable", longint'({peak_bin, peak_mag, frame_err}), longint'(hold));
      chk("tready_low_in_report", longint'(s_axis_tready), 0);
      if (peak_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("peak_bin", longint'(peak_bin), longint'(e.bin));
          chk("peak_mag", longint'(peak_mag), e.mag);
          chk("frame_err", longint'(frame_err), longint'(e.err));
        end
      end
    end
    pv_prev = !rst_in && peak_valid;
    hold    = {peak_bin, peak_mag, frame_err};
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(100, cx(1000, 0), -1, 0, -1, 0, NFFT, 1, 100, 1000000, 0);
`ifdef FFT_PEAK_DC_EN
    vecs[1] = mk(0, cx(20000, 0), 50, cx(0, -500), 300, cx(0, -500), NFFT, 1, 0, 400000000, 0);
`else
    vecs[1] = mk(0, cx(20000, 0), 50, cx(0, -500), 300, cx(0, -500), NFFT, 1, 50, 250000, 0);
`endif
    vecs[2] = mk(1500, cx(-32768, -32768), 7, cx(-32768, -32768), -1, 0, NFFT, 1,
                 7, 64'd2147483648, 0);
    vecs[3] = mk(30, cx(3, 4), -1, 0, -1, 0, 1000, 1, 30, 25, 1);
    vecs[4] = mk(200, cx(0, 7), -1, 0, -1, 0, NFFT, 0, 200, 49, 1);
    vecs[5] = mk(-1, 0, -1, 0, -1, 0, NFFT, 1, 0, 0, 0);
    vecs[6] = mk(1024, cx(100, 0), 1023, cx(50, 0), -1, 0, NFFT, 1, 1023, 2500, 0);
    vecs[7] = mk(600, cx(0, 9), 400, cx(9, 0), -1, 0, NFFT, 1, 400, 81, 0);
    vecs[8] = mk(10, cx(11, -2), -1, 0, -1, 0, NFFT, 1, 10, 125, 0);
    vecs[9] = mk(20, cx(-6, 8), -1, 0, -1, 0, NFFT, 1, 20, 100, 0);
    vecs[10] = mk(5, cx(123, 0), -1, 0, -1, 0, NFFT, 1, 5, 15129, 0);

    rst_in        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    peak_ready    = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst_tready", longint'(s_axis_tready), 0);
    chk("rst_peak_valid", longint'(peak_valid), 0);
    chk("rst_peak_bin", longint'(peak_bin), 0);
    chk("rst_peak_mag", longint'(peak_mag), 0);
    chk("rst_frame_err", longint'(frame_err), 0);
    rst_in = 1'b0;
    #1;
    chk("tready_before_first_clk", longint'(s_axis_tready), 0);
    @(posedge clk_in);
    #1;
    chk("tready_after_release", longint'(s_axis_tready), 1);

    // Table-driven frames, odd entries with random tvalid gaps
    for (int i = 0; i < 8; i++) begin
      send_frame(i, i[0]);
      wait_empty();
    end

    // Backpressure: result held 20 cycles while the next frame waits
    peak_ready = 1'b0;
    fork
      begin
        send_frame(8, 1);
        send_frame(9, 1);
      end
      begin
        bit seen;
        seen = 0;
        for (int w = 0; w < 20000; w++) begin
          @(negedge clk_in);
          if (peak_valid) begin
            seen = 1;
            break;
          end
        end
        if (!seen) chk("bp_valid_timeout", 0, 1);
        repeat (20) @(negedge clk_in);
        peak_ready = 1'b1;
      end
    join
    wait_empty();

    // Reset in the middle of a frame
    for (int b = 0; b < 800; b++) put_beat(beat_data(10, b), 1'b0);
    @(negedge clk_in);
    s_axis_tvalid = 1'b0;
    rst_in = 1'b1;
    #1;
    chk("midrst_tready", longint'(s_axis_tready), 0);
    chk("midrst_peak_valid", longint'(peak_valid), 0);
    chk("midrst_peak_bin", longint'(peak_bin), 0);
    chk("midrst_peak_mag", longint'(peak_mag), 0);
    chk("midrst_frame_err", longint'(frame_err), 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    send_frame(10, 0);
    wait_empty();

    repeat (5) @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
